// File: rtl/bram_ctrl_pkg.sv
// rtl/bram_ctrl_pkg.sv - shared widths, response depth and request type for the BRAM port initiator
package bram_ctrl_pkg;

   localparam int BRAM_ADDR_W = 13;
   localparam int BRAM_DATA_W = 2;
   localparam int RSP_DEPTH   = 2;

   typedef struct packed {
      logic                   we;
      logic [BRAM_ADDR_W-1:0] addr;
      logic [BRAM_DATA_W-1:0] data;
      logic [BRAM_DATA_W-1:0] wem;
   } bram_req_t;

endpackage

// File: rtl/bram_rsp_fifo.sv
// rtl/bram_rsp_fifo.sv - small response FIFO holding read data until the consumer takes it
module bram_rsp_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 2
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_push_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_pop_data,
   output logic [$clog2(DEPTH+1)-1:0] o_cnt
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic             w_do_pop;
   logic             w_do_push;

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign w_do_pop   = i_pop && (r_cnt != '0);
   assign w_do_push  = i_push && ((r_cnt != FULL_CNT) || w_do_pop);
   assign o_pop_data = r_mem[r_rd_ptr];
   assign o_cnt      = r_cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_do_pop) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
      !(i_push && !w_do_pop && (r_cnt == FULL_CNT)));

endmodule

// File: rtl/bram_port_initiator.sv
// rtl/bram_port_initiator.sv - request/response front end driving a single-cycle BRAM port
module bram_port_initiator
   import bram_ctrl_pkg::*;
#(
   parameter int ADDR_W = BRAM_ADDR_W,
   parameter int DATA_W = BRAM_DATA_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   input  logic [DATA_W-1:0] req_wem,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] A,
   output logic [DATA_W-1:0] D,
   output logic              WE,
   output logic [DATA_W-1:0] WEM,
   output logic              CE,
   input  logic [DATA_W-1:0] Q
);
   localparam int CNT_W = $clog2(RSP_DEPTH+1);
   localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(RSP_DEPTH);

   logic             w_accept;
   logic             w_pop;
   logic             r_rd_pend;
   logic [CNT_W-1:0] w_fifo_cnt;
   logic [CNT_W:0]   w_credit_used;
   logic [CNT_W:0]   w_credit_next;

   // Every read in flight or buffered holds one FIFO slot; a pop this cycle frees one early.
   assign w_credit_used = (CNT_W+1)'(w_fifo_cnt) + (CNT_W+1)'(r_rd_pend);
   assign w_credit_next = w_credit_used - (CNT_W+1)'(w_pop);
   assign req_ready     = !RST && (w_credit_next < CREDIT_MAX);
   assign w_accept      = req_valid && req_ready;

   assign rsp_valid = (w_fifo_cnt != '0);
   assign w_pop     = rsp_valid && rsp_ready;

   assign CE  = w_accept;
   assign WE  = w_accept && req_we;
   assign A   = w_accept ? req_addr : '0;
   assign D   = w_accept ? req_data : '0;
   assign WEM = w_accept ? req_wem  : '0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_rd_pend <= 1'b0;
      else     r_rd_pend <= w_accept && !req_we;
   end

   bram_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (DATA_W)
   ) u_rsp_fifo (
      .CLK         (CLK),
      .RST         (RST),
      .i_push      (r_rd_pend),
      .i_push_data (Q),
      .i_pop       (w_pop),
      .o_pop_data  (rsp_data),
      .o_cnt       (w_fifo_cnt)
   );

endmodule

// File: tb/tb_bram_port_initiator.sv
// tb/tb_bram_port_initiator.sv - directed bench for bram_port_initiator against an 8192x2 memory model
module tb_bram_port_initiator;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 2;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [DATA_W-1:0] req_data = '0;
   logic [DATA_W-1:0] req_wem = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [DATA_W-1:0] rsp_data;
   logic [ADDR_W-1:0] A;
   logic [DATA_W-1:0] D;
   logic              WE;
   logic [DATA_W-1:0] WEM;
   logic              CE;
   logic [DATA_W-1:0] Q = '0;

   int n_cmp = 0;
   int n_bad = 0;
   int n_acc = 0;
   int acc0;
   logic [DATA_W-1:0] q_got[$];
   logic [DATA_W-1:0] mem [8192];

   bram_port_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_data(req_data), .req_wem(req_wem),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .A(A), .D(D), .WE(WE), .WEM(WEM), .CE(CE), .Q(Q)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (CE && WE) mem[A] <= (mem[A] & ~WEM) | (D & WEM);
      if (CE && !WE) Q <= mem[A];
   end

   always @(negedge CLK) begin
      if (!RST && rsp_valid && rsp_ready) q_got.push_back(rsp_data);
      if (!RST && req_valid && req_ready) n_acc++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_data  = '0;
      req_wem   = '0;
   endtask

   task automatic do_write(input logic [12:0] a, input logic [1:0] d, input logic [1:0] m);
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_data = d; req_wem = m;
      #1;
      check("wr_ready", req_ready, 1);
      check("wr_ce", CE, 1);
      check("wr_we", WE, 1);
      check("wr_a", A, a);
      check("wr_d", D, d);
      check("wr_wem", WEM, m);
      step();
      idle();
   endtask

   task automatic read_expect(input string tag, input logic [12:0] a, input logic [1:0] exp);
      int waited = 0;
      rsp_ready = 1'b1;
      q_got.delete();
      req_valid = 1'b1; req_we = 1'b0; req_addr = a;
      #1;
      check({tag, "_rdy"}, req_ready, 1);
      step();
      idle();
      while (q_got.size() == 0 && waited < 8) begin
         step();
         waited++;
      end
      check({tag, "_seen"}, q_got.size(), 1);
      if (q_got.size() != 0) check({tag, "_data"}, q_got[0], exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = '0;

      // Reset with a request being offered: every output must stay quiet.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 13'h123; req_data = 2'b11; req_wem = 2'b11;
      rsp_ready = 1'b1;
      step(); step();
      check("rst_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_ce", CE, 0);
      check("rst_we", WE, 0);
      check("rst_a", A, 0);
      check("rst_d", D, 0);
      check("rst_wem", WEM, 0);
      idle();
      RST = 1'b0;
      #1;
      check("rel_ready", req_ready, 1);
      step();

      // S1: write then read 0x0005, latency of two cycles.
      do_write(13'h0005, 2'b10, 2'b11);
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 13'h0005;
      #1;
      check("s1_rd_ready", req_ready, 1);
      check("s1_rd_ce", CE, 1);
      check("s1_rd_we", WE, 0);
      check("s1_rd_a", A, 13'h0005);
      step();
      idle();
      #1;
      check("s1_idle_ce", CE, 0);
      check("s1_lat_n1", rsp_valid, 0);
      step();
      check("s1_lat_n2", rsp_valid, 1);
      check("s1_data", rsp_data, 2'b10);
      step();
      check("s1_drained", rsp_valid, 0);

      // S2: top address with a masked second write.
      do_write(13'h1FFF, 2'b11, 2'b11);
      do_write(13'h1FFF, 2'b00, 2'b01);
      read_expect("s2", 13'h1FFF, 2'b10);
      repeat (2) step();

      // S3: four back-to-back reads with the consumer always ready.
      for (int i = 0; i < 4; i++) do_write(13'(i), 2'(i), 2'b11);
      q_got.delete();
      acc0 = n_acc;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_we = 1'b0; req_addr = 13'(i);
         #1;
         check("s3_ready", req_ready, 1);
         step();
      end
      idle();
      repeat (4) step();
      check("s3_accepts", n_acc - acc0, 4);
      check("s3_count", q_got.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < q_got.size()) check("s3_order", q_got[i], i);

      // S4: consumer stalled, third read held back until a slot frees.
      do_write(13'd8, 2'd1, 2'b11);
      do_write(13'd9, 2'd2, 2'b11);
      do_write(13'd10, 2'd3, 2'b11);
      rsp_ready = 1'b0;
      q_got.delete();
      acc0 = n_acc;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 13'd8;
      #1;
      check("s4_rdy0", req_ready, 1);
      step();
      req_addr = 13'd9;
      #1;
      check("s4_rdy1", req_ready, 1);
      step();
      req_addr = 13'd10;
      #1;
      check("s4_full_a", req_ready, 0);
      step();
      #1;
      check("s4_full_b", req_ready, 0);
      check("s4_hold_v", rsp_valid, 1);
      check("s4_hold_d", rsp_data, 1);
      step();
      check("s4_still_v", rsp_valid, 1);
      check("s4_still_d", rsp_data, 1);
      rsp_ready = 1'b1;
      #1;
      check("s4_freed", req_ready, 1);
      step();
      idle();
      repeat (5) step();
      check("s4_accepts", n_acc - acc0, 3);
      check("s4_count", q_got.size(), 3);
      for (int i = 0; i < 3; i++)
         if (i < q_got.size()) check("s4_order", q_got[i], i + 1);

      // S5: FIFO full, then pop and accept together while reads keep streaming.
      rsp_ready = 1'b0;
      q_got.delete();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 13'd0;
      step();
      req_addr = 13'd1;
      step();
      idle();
      step();
      check("s5_full", req_ready, 0);
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 13'd2;
      #1;
      check("s5_rdy_a", req_ready, 1);
      check("s5_v_a", rsp_valid, 1);
      step();
      req_addr = 13'd3;
      #1;
      check("s5_rdy_b", req_ready, 1);
      check("s5_v_b", rsp_valid, 1);
      step();
      idle();
      #1;
      check("s5_v_c", rsp_valid, 1);
      repeat (4) step();
      check("s5_count", q_got.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < q_got.size()) check("s5_order", q_got[i], i);

      // S6: reset lands while a read is in flight.
      q_got.delete();
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 13'h0005;
      #1;
      check("s6_rdy", req_ready, 1);
      step();
      idle();
      RST = 1'b1;
      #1;
      check("s6_rst_ready", req_ready, 0);
      check("s6_rst_v", rsp_valid, 0);
      check("s6_rst_ce", CE, 0);
      step();
      RST = 1'b0;
      #1;
      check("s6_rel_ready", req_ready, 1);
      repeat (4) begin
         check("s6_no_rsp", rsp_valid, 0);
         step();
      end
      check("s6_q_empty", q_got.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
